// File: rtl/mil_bc_msg_seq_if.sv
// Word-datapath bundle for the 1553 BC sequencer: transmitter handshake,
// BC->RT data buffer read port, receiver word stream and RT->BC write port.
interface mil_bc_msg_seq_if;
    logic        tx_req;
    logic        tx_cw;
    logic [15:0] tx_dat;
    logic        tx_ack;
    logic        tx_done;
    logic [4:0]  d_addr;
    logic [15:0] d_in;
    logic        rx_ok;
    logic [15:0] rx_dat;
    logic        rx_cw;
    logic        rx_perr;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [15:0] rd_dat;

    // Sequencer side.
    modport master (
        output tx_req, tx_cw, tx_dat, d_addr, rd_we, rd_addr, rd_dat,
        input  tx_ack, tx_done, d_in, rx_ok, rx_dat, rx_cw, rx_perr
    );

    // Datapath / buffer side.
    modport slave (
        input  tx_req, tx_cw, tx_dat, d_addr, rd_we, rd_addr, rd_dat,
        output tx_ack, tx_done, d_in, rx_ok, rx_dat, rx_cw, rx_perr
    );
endinterface

// File: rtl/mil_bc_msg_seq.sv
// MIL-STD-1553 bus-controller message sequencer: one command word in, one
// complete BC<->RT transfer out, finished by a single done pulse and error code.
module mil_bc_msg_seq #(
    parameter int unsigned Fclk   = 50000000,
    parameter int unsigned TXvel  = 1000000,
    parameter int unsigned T_RESP = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      cmd,
    output logic             busy,
    output logic             done,
    output logic [2:0]       err,
    output logic [15:0]      status,
    mil_bc_msg_seq_if.master bus
);
    localparam int unsigned DIV        = Fclk / TXvel;
    localparam int unsigned DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned TMO_W      = $clog2(T_RESP + 1);
    localparam logic [4:0]  BCAST_ADDR = 5'd31;

    typedef enum logic [2:0] {
        IDLE, SEND_CMD, SEND_DAT, WAIT_STAT, RECV_DAT, FIN
    } state_t;

    typedef enum logic [2:0] {
        ERR_OK      = 3'd0,
        ERR_TIMEOUT = 3'd1,
        ERR_PARITY  = 3'd2,
        ERR_SYNC    = 3'd3,
        ERR_ADDR    = 3'd4
    } err_t;

    state_t           state_q, state_d;
    logic [15:0]      cmd_q, cmd_d;
    logic [5:0]       n_q, n_d;          // word count, 1..32
    logic [4:0]       idx_q, idx_d;      // current data word index
    logic [DIV_W-1:0] div_q, div_d;      // bit-time divider
    logic [TMO_W-1:0] tmo_q, tmo_d;      // response timeout in bit times
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    err_t             err_q, err_d;
    logic [15:0]      status_q, status_d;
    logic             tx_req_q, tx_req_d;
    logic             tx_cw_q, tx_cw_d;
    logic             rd_we_q, rd_we_d;
    logic [4:0]       rd_addr_q, rd_addr_d;
    logic [15:0]      rd_dat_q, rd_dat_d;

    logic is_tx_mode, is_bcast, last_word, tick, timeout;
    logic fin;
    err_t fin_code;

    assign is_tx_mode = cmd_q[10];
    assign is_bcast   = (cmd_q[15:11] == BCAST_ADDR);
    assign last_word  = ({1'b0, idx_q} == (n_q - 6'd1));
    assign tick       = (div_q == DIV_W'(DIV - 1));
    assign timeout    = tick && (tmo_q == TMO_W'(T_RESP - 1));

    // Next-state logic for the message sequencer and all registered outputs.
    always_comb begin
        // NOTE: every _d starts from its hold value so no branch can infer a latch.
        state_d   = state_q;
        cmd_d     = cmd_q;
        n_d       = n_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        status_d  = status_q;
        tx_req_d  = tx_req_q;
        tx_cw_d   = tx_cw_q;
        rd_we_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_dat_d  = rd_dat_q;
        fin       = 1'b0;
        fin_code  = ERR_OK;
        div_d     = '0;
        tmo_d     = '0;

        // The response timer only runs while a word is expected from the RT.
        if (state_q == WAIT_STAT || state_q == RECV_DAT) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            tmo_d = tick ? tmo_q + TMO_W'(1) : tmo_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    cmd_d    = cmd;
                    n_d      = (cmd[4:0] == 5'd0) ? 6'd32 : {1'b0, cmd[4:0]};
                    idx_d    = 5'd0;
                    err_d    = ERR_OK;
                    busy_d   = 1'b1;
                    tx_req_d = 1'b1;
                    tx_cw_d  = 1'b1;
                    state_d  = SEND_CMD;
                end
            end

            SEND_CMD, SEND_DAT: begin
                if (tx_req_q) begin
                    if (bus.tx_ack) tx_req_d = 1'b0;
                end else if (bus.tx_done) begin
                    if (state_q == SEND_CMD && !is_tx_mode) begin
                        idx_d    = 5'd0;
                        tx_req_d = 1'b1;
                        tx_cw_d  = 1'b0;
                        state_d  = SEND_DAT;
                    end else if (state_q == SEND_DAT && !last_word) begin
                        idx_d    = idx_q + 5'd1;
                        tx_req_d = 1'b1;
                    end else if (state_q == SEND_DAT && is_bcast) begin
                        fin = 1'b1;
                    end else begin
                        div_d   = '0;
                        tmo_d   = '0;
                        state_d = WAIT_STAT;
                    end
                end
            end

            WAIT_STAT: begin
                if (bus.rx_ok) begin
                    status_d = bus.rx_dat;
                    if (bus.rx_perr) begin
                        fin = 1'b1; fin_code = ERR_PARITY;
                    end else if (!bus.rx_cw) begin
                        fin = 1'b1; fin_code = ERR_SYNC;
                    end else if (bus.rx_dat[15:11] != cmd_q[15:11]) begin
                        fin = 1'b1; fin_code = ERR_ADDR;
                    end else if (is_tx_mode) begin
                        idx_d   = 5'd0;
                        div_d   = '0;
                        tmo_d   = '0;
                        state_d = RECV_DAT;
                    end else begin
                        fin = 1'b1;
                    end
                end else if (timeout) begin
                    fin = 1'b1; fin_code = ERR_TIMEOUT;
                end
            end

            RECV_DAT: begin
                if (bus.rx_ok) begin
                    if (bus.rx_perr) begin
                        fin = 1'b1; fin_code = ERR_PARITY;
                    end else if (bus.rx_cw) begin
                        fin = 1'b1; fin_code = ERR_SYNC;
                    end else begin
                        rd_we_d   = 1'b1;
                        rd_addr_d = idx_q;
                        rd_dat_d  = bus.rx_dat;
                        if (last_word) begin
                            fin = 1'b1;
                        end else begin
                            idx_d = idx_q + 5'd1;
                            div_d = '0;
                            tmo_d = '0;
                        end
                    end
                end else if (timeout) begin
                    fin = 1'b1; fin_code = ERR_TIMEOUT;
                end
            end

            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        if (fin) begin
            done_d  = 1'b1;
            err_d   = fin_code;
            state_d = FIN;
        end
    end

    // State and output registers; reset aborts any message in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            n_q       <= '0;
            idx_q     <= '0;
            div_q     <= '0;
            tmo_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= ERR_OK;
            status_q  <= '0;
            tx_req_q  <= 1'b0;
            tx_cw_q   <= 1'b0;
            rd_we_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_dat_q  <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            div_q     <= div_d;
            tmo_q     <= tmo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            status_q  <= status_d;
            tx_req_q  <= tx_req_d;
            tx_cw_q   <= tx_cw_d;
            rd_we_q   <= rd_we_d;
            rd_addr_q <= rd_addr_d;
            rd_dat_q  <= rd_dat_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign status      = status_q;
    assign bus.tx_req  = tx_req_q;
    assign bus.tx_cw   = tx_cw_q;
    // The data word comes straight from the buffer addressed by the word index.
    assign bus.tx_dat  = (state_q == SEND_CMD) ? cmd_q :
                         (state_q == SEND_DAT) ? bus.d_in : 16'h0000;
    assign bus.d_addr  = idx_q;
    assign bus.rd_we   = rd_we_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.rd_dat  = rd_dat_q;
endmodule

// File: tb/tb_mil_bc_msg_seq.sv
// Self-checking bench for mil_bc_msg_seq: directed cases plus randomized
// messages, all compared against a message-level reference model.
module tb_mil_bc_msg_seq;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cmd   = 16'h0000;
    logic        busy, done;
    logic [2:0]  err;
    logic [15:0] status;
    logic [15:0] dbuf [32];

    mil_bc_msg_seq_if bus_if ();

    assign bus_if.d_in = dbuf[bus_if.d_addr];

    mil_bc_msg_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmd    (cmd),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .status (status),
        .bus    (bus_if)
    );

    always #10 clk = ~clk;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- scenario and reference model ----------------
    typedef struct {
        logic        cw;
        logic [4:0]  addr;
        logic [15:0] dat;
        logic        chk_addr;
    } tx_exp_t;

    logic [15:0] s_cmd;
    int          n_rx;
    logic [15:0] rx_w   [40];
    logic        rx_c   [40];
    logic        rx_p   [40];
    int          rx_gap [40];

    tx_exp_t     exp_tx [$];
    int          n_use;
    logic        exp_we [40];
    logic [4:0]  exp_wa [40];
    logic [15:0] exp_wd [40];
    logic [2:0]  exp_err;
    logic [15:0] exp_status;
    logic [15:0] cur_status;
    logic        exp_timeout, exp_no_resp;

    // Message outcome from the protocol rules: which words go out, how many
    // RT words are consumed, which get written back, and the final code.
    function automatic void build_expect();
        int      n;
        logic    tr, bc;
        tx_exp_t t;
        n  = (s_cmd[4:0] == 5'd0) ? 32 : int'(s_cmd[4:0]);
        tr = s_cmd[10];
        bc = (s_cmd[15:11] == 5'd31);
        exp_tx.delete();
        t.cw = 1'b1; t.addr = 5'd0; t.dat = s_cmd; t.chk_addr = 1'b0;
        exp_tx.push_back(t);
        if (!tr) begin
            for (int i = 0; i < n; i++) begin
                t.cw = 1'b0; t.addr = 5'(i); t.dat = dbuf[i]; t.chk_addr = 1'b1;
                exp_tx.push_back(t);
            end
        end
        for (int k = 0; k < 40; k++) begin
            exp_we[k] = 1'b0; exp_wa[k] = 5'd0; exp_wd[k] = 16'h0;
        end
        n_use = 0; exp_timeout = 1'b0; exp_no_resp = 1'b0;
        exp_err = 3'd0; exp_status = cur_status;
        if (!tr && bc) begin exp_no_resp = 1'b1; return; end
        if (n_rx == 0) begin exp_timeout = 1'b1; exp_err = 3'd1; return; end
        n_use = 1;
        exp_status = rx_w[0];
        if (rx_p[0])                          begin exp_err = 3'd2; return; end
        if (!rx_c[0])                         begin exp_err = 3'd3; return; end
        if (rx_w[0][15:11] != s_cmd[15:11])   begin exp_err = 3'd4; return; end
        if (!tr) return;
        for (int k = 0; k < n; k++) begin
            if (k + 1 >= n_rx) begin exp_timeout = 1'b1; exp_err = 3'd1; return; end
            n_use = k + 2;
            if (rx_p[k+1]) begin exp_err = 3'd2; return; end
            if (rx_c[k+1]) begin exp_err = 3'd3; return; end
            exp_we[k+1] = 1'b1;
            exp_wa[k+1] = 5'(k);
            exp_wd[k+1] = rx_w[k+1];
        end
    endfunction

    // ---------------- bus agents ----------------
    task automatic send_tx_word(input tx_exp_t t, input int w);
        check($sformatf("tx_req w%0d", w), bus_if.tx_req, 1);
        check($sformatf("tx_cw w%0d", w), bus_if.tx_cw, t.cw);
        check($sformatf("tx_dat w%0d", w), bus_if.tx_dat, t.dat);
        if (t.chk_addr) check($sformatf("d_addr w%0d", w), bus_if.d_addr, t.addr);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        check($sformatf("tx_dat held w%0d", w), {bus_if.tx_req, bus_if.tx_dat}, {1'b1, t.dat});
        bus_if.tx_ack = 1'b1;
        @(negedge clk);
        bus_if.tx_ack = 1'b0;
        check($sformatf("tx_req drop w%0d", w), bus_if.tx_req, 0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bus_if.tx_done = 1'b1;
        @(negedge clk);
        bus_if.tx_done = 1'b0;
    endtask

    task automatic drive_rx(input logic [15:0] w, input logic c, input logic p);
        bus_if.rx_ok   = 1'b1;
        bus_if.rx_dat  = w;
        bus_if.rx_cw   = c;
        bus_if.rx_perr = p;
        @(negedge clk);
        bus_if.rx_ok   = 1'b0;
        bus_if.rx_dat  = 16'($urandom);
        bus_if.rx_cw   = 1'($urandom);
        bus_if.rx_perr = 1'($urandom);
    endtask

    task automatic set_rx(input int k, input logic [15:0] w, input logic c,
                          input logic p, input int gap);
        rx_w[k] = w; rx_c[k] = c; rx_p[k] = p; rx_gap[k] = gap;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ctl"}, {busy, done, err, bus_if.tx_req, bus_if.tx_cw,
                              bus_if.d_addr, bus_if.rd_we, bus_if.rd_addr}, 0);
        check({tag, " status"}, status, 0);
        check({tag, " tx_dat"}, bus_if.tx_dat, 0);
        check({tag, " rd_dat"}, bus_if.rd_dat, 0);
    endtask

    // Runs one whole message from start to the cycle after done.
    task automatic run_msg(input string name);
        int cnt;
        build_expect();
        start = 1'b1;
        cmd   = s_cmd;
        @(negedge clk);
        start = 1'b0;
        cmd   = 16'($urandom);
        check($sformatf("%s busy", name), busy, 1);
        foreach (exp_tx[i]) send_tx_word(exp_tx[i], i);
        if (exp_no_resp) begin
            check($sformatf("%s bcast done", name), done, 1);
        end else begin
            for (int k = 0; k < n_use; k++) begin
                repeat (rx_gap[k]) @(negedge clk);
                drive_rx(rx_w[k], rx_c[k], rx_p[k]);
                check($sformatf("%s rd_we r%0d", name, k), bus_if.rd_we, exp_we[k]);
                if (exp_we[k]) begin
                    check($sformatf("%s rd_addr r%0d", name, k), bus_if.rd_addr, exp_wa[k]);
                    check($sformatf("%s rd_dat r%0d", name, k), bus_if.rd_dat, exp_wd[k]);
                end
                check($sformatf("%s done r%0d", name, k), done,
                      (k == n_use - 1) && !exp_timeout);
            end
            if (exp_timeout) begin
                cnt = 1;
                while (done !== 1'b1 && cnt < 800) begin
                    @(negedge clk);
                    cnt++;
                end
                check($sformatf("%s timeout latency", name), cnt, 701);
            end
        end
        check($sformatf("%s err", name), err, exp_err);
        check($sformatf("%s status", name), status, exp_status);
        check($sformatf("%s busy with done", name), busy, 1);
        cur_status = exp_status;
        @(negedge clk);
        check($sformatf("%s idle after", name), {busy, done}, 0);
        check($sformatf("%s err held", name), err, exp_err);
    endtask

    initial begin
        #1_900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        bus_if.tx_ack  = 1'b0;
        bus_if.tx_done = 1'b0;
        bus_if.rx_ok   = 1'b0;
        bus_if.rx_dat  = 16'h0;
        bus_if.rx_cw   = 1'b0;
        bus_if.rx_perr = 1'b0;
        cur_status     = 16'h0;
        foreach (dbuf[i]) dbuf[i] = 16'($urandom);

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("in reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("after reset");

        // Receive mode, two data words, status 5 us after the last word
        s_cmd = 16'h0822; dbuf[0] = 16'h1111; dbuf[1] = 16'h2222;
        n_rx = 1; set_rx(0, 16'h0800, 1'b1, 1'b0, 249);
        run_msg("recv");

        // Transmit mode, one data word written back
        s_cmd = 16'h0C21;
        n_rx = 2; set_rx(0, 16'h0800, 1'b1, 1'b0, 7); set_rx(1, 16'hA5A5, 1'b0, 1'b0, 20);
        run_msg("xmit");

        // No response at all
        s_cmd = 16'h0822; n_rx = 0;
        run_msg("noresp");

        // Status faults in priority order
        s_cmd = 16'h0822; n_rx = 1; set_rx(0, 16'h1000, 1'b1, 1'b0, 3);
        run_msg("addr");
        set_rx(0, 16'h1000, 1'b1, 1'b1, 3);
        run_msg("parity");
        set_rx(0, 16'h1000, 1'b0, 1'b0, 3);
        run_msg("sync");

        // Status on the very cycle the timeout would fire
        s_cmd = 16'h0822; n_rx = 1; set_rx(0, 16'h0801, 1'b1, 1'b0, 699);
        run_msg("race");

        // Broadcast receive, 32 words, no status phase
        s_cmd = 16'hF820; foreach (dbuf[i]) dbuf[i] = 16'($urandom); n_rx = 0;
        run_msg("bcast");

        // Reset during the second data word
        s_cmd = 16'h0822; n_rx = 1; set_rx(0, 16'h0800, 1'b1, 1'b0, 2);
        build_expect();
        start = 1'b1; cmd = s_cmd;
        @(negedge clk);
        start = 1'b0;
        send_tx_word(exp_tx[0], 0);
        send_tx_word(exp_tx[1], 1);
        check("abort d_addr", bus_if.d_addr, 1);
        bus_if.tx_ack = 1'b1;
        @(negedge clk);
        bus_if.tx_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        cur_status = 16'h0;
        seen = 1'b0;
        bus_if.tx_done = 1'b1;
        @(negedge clk);
        bus_if.tx_done = 1'b0;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        check("abort no done", seen, 0);
        run_msg("after abort");

        // Randomized messages
        for (int m = 0; m < 24; m++) begin
            logic [4:0] rt, wc;
            logic       tr;
            int         n;
            rt = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
            tr = 1'($urandom);
            wc = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 4));
            s_cmd = {rt, tr, 5'($urandom), wc};
            foreach (dbuf[i]) dbuf[i] = 16'($urandom);
            n = (wc == 5'd0) ? 32 : int'(wc);
            n_rx = tr ? n + 1 : 1;
            if ($urandom_range(0, 9) == 0) n_rx = $urandom_range(0, n_rx - 1);
            for (int k = 0; k < n_rx; k++) begin
                rx_w[k]   = 16'($urandom);
                rx_c[k]   = (k == 0);
                if ($urandom_range(0, 19) == 0) rx_c[k] = ~rx_c[k];
                rx_p[k]   = ($urandom_range(0, 19) == 0);
                rx_gap[k] = $urandom_range(0, 12);
            end
            if (n_rx > 0)
                rx_w[0][15:11] = ($urandom_range(0, 9) == 0) ? 5'($urandom) : rt;
            run_msg($sformatf("rnd%0d", m));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mil_bc_msg_seq.md
# mil_bc_msg_seq

Bus-controller message sequencer for the MIL-STD-1553 (Manchester II, 1 Mbit/s) link. It takes one command word and runs one complete BC↔RT transfer:
- drives the word transmitter through a request/acknowledge handshake;
- supervises the RT response via the word receiver (status word, then data words);
- enforces response timeouts and reports one completion code per message.

It sits between the host-side data buffers and the transmit/receive word datapaths.

## Interface
Parameters:
- Fclk, 50000000, system clock frequency in Hz
- TXvel, 1000000, line bit rate in bit/s; one bit time = Fclk/TXvel clocks (50)
- T_RESP, 14, response timeout in bit times

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a message; sampled only in IDLE
- cmd  in  16  command word: [15:11] RT address, [10] T/R (1 = RT transmits), [9:5] subaddress, [4:0] word count (0 = 32)
- busy  out  1  high from the cycle after start is accepted until the cycle done is high
- done  out  1  one-cycle completion pulse
- err  out  3  completion code, valid with done and held until the next start: 0 ok, 1 timeout, 2 parity, 3 wrong sync type, 4 status address mismatch
- status  out  16  last status word received
- tx_req  out  1  word transmit request
- tx_cw  out  1  1 = command sync, 0 = data sync for the requested word
- tx_dat  out  16  word to transmit
- tx_ack  in  1  one-cycle pulse: transmitter latched tx_dat/tx_cw
- tx_done  in  1  one-cycle pulse: word (including parity) finished on line
- d_addr  out  5  index of the BC→RT data word to fetch
- d_in  in  16  buffer read data; combinational from d_addr
- rx_ok  in  1  one-cycle pulse: a word was received
- rx_dat  in  16  received word, valid with rx_ok
- rx_cw  in  1  1 = command/status sync on the received word
- rx_perr  in  1  parity error on the received word, valid with rx_ok
- rd_we  out  1  write strobe for RT→BC data
- rd_addr  out  5  write index
- rd_dat  out  16  write data

## Operation
- Reset values:
  - All outputs 0; state IDLE.
  - Word index, timeout counter and bit-tick divider are 0.
  - cmd latch is 0.
- Start acceptance:
  - start in IDLE latches cmd and sets N = cmd[4:0], with 0 decoded as 32.
  - start outside IDLE is ignored.
- States:
  - IDLE
  - SEND_CMD: tx_cw = 1, tx_dat = latched cmd.
  - SEND_DAT: tx_cw = 0, tx_dat = d_in, d_addr = word index.
  - WAIT_STAT
  - RECV_DAT
  - FIN: done = 1 for one cycle, then IDLE.
- Transmit handshake:
  - In SEND_* the block raises tx_req and holds tx_req/tx_cw/tx_dat stable until tx_ack is sampled.
  - tx_req drops the cycle after tx_ack.
  - The block then waits for tx_done before moving on.
  - tx_ack and tx_done are never expected together for the same word.
- Receive mode (T/R = 0):
  - SEND_CMD → SEND_DAT ×N; the index runs 0..N-1 and wraps from 31 to 0 only after the 32nd word.
  - After the last tx_done → WAIT_STAT.
- Transmit mode (T/R = 1):
  - SEND_CMD → WAIT_STAT → RECV_DAT ×N.
  - Each accepted data word pulses rd_we with rd_addr = index 0..N-1 and rd_dat = rx_dat.
  - After the Nth word → FIN, err = 0.
- Broadcast (address 31) with T/R = 0: no status is expected; after the last tx_done → FIN, err = 0.
- WAIT_STAT, on rx_ok, checks in priority order:
  - rx_perr → err 2
  - else rx_cw = 0 → err 3
  - else rx_dat[15:11] ≠ cmd[15:11] → err 4
  - else status is accepted.
  - status is loaded on every rx_ok in this state, even when an error results.
  - An error → FIN. Success → FIN (receive mode) or RECV_DAT (transmit mode).
- RECV_DAT, on rx_ok:
  - rx_perr → err 2; rx_cw = 1 → err 3.
  - An error → FIN without rd_we.
- rx_ok outside WAIT_STAT/RECV_DAT is ignored.

## Timing
- Bit tick:
  - The divider counts 0..Fclk/TXvel-1 and restarts at 0 on every entry to WAIT_STAT/RECV_DAT and after every accepted received word.
  - A tick fires when the divider wraps.
- Timeout:
  - The counter clears with the divider and increments on each tick.
  - At T_RESP ticks (700 clocks after entry, default) → FIN with err 1.
  - If rx_ok arrives in the same cycle the timeout is reached, rx_ok wins.
- Latencies:
  - start → busy and tx_req high: 1 clock.
  - tx_done → next tx_req: 1 clock.
  - rx_ok → rd_we: 1 clock.
  - Last event → done: 1 clock; busy falls together with done.
- rst_n low mid-message aborts immediately:
  - All outputs return to reset values; no done pulse.
  - After release the block idles until the next start.

## Test plan
- cmd 16'h0822 (RT 1, receive, SA 1, WC 2), d_in = {16'h1111, 16'h2222}; status 16'h0800 with rx_cw = 1 sent 5 µs after the last tx_done → 3 tx words with tx_cw 1,0,0; done, err 0, status 16'h0800.
- cmd 16'h0C21 (RT 1, transmit, WC 1); status 16'h0800, then 16'hA5A5 with rx_cw = 0 → rd_we once, rd_addr 0, rd_dat 16'hA5A5; done, err 0.
- cmd 16'h0822 with no response → done exactly 701 clocks after the last tx_done, err 1.
- Status 16'h1000 for cmd 16'h0822 → err 4, status 16'h1000; repeat with rx_perr = 1 → err 2; repeat with rx_cw = 0 → err 3.
- Broadcast cmd 16'hF820 (WC 0 = 32) → 33 transmitted words with d_addr 0..31; done 1 clock after the 33rd tx_done; no wait for status; err 0.
- Assert rst_n low during the 2nd data word → all outputs 0, no done; a new start then runs cleanly.
